// File: rtl/saturn_pkg.sv
// saturn_pkg: FSM state encodings, opcode nibble constants and jump-length codes for the jump decoder.
package saturn_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_B0, ST_B8, ST_OFFSET, ST_SKIP} state_t;
   localparam logic [3:0] OP_B0     = 4'h0;
   localparam logic [3:0] OP_GOC    = 4'h4;
   localparam logic [3:0] OP_GONC   = 4'h5;
   localparam logic [3:0] OP_GOTO   = 4'h6;
   localparam logic [3:0] OP_GOSUB  = 4'h7;
   localparam logic [3:0] OP_8X     = 4'h8;
   localparam logic [3:0] OP_GOLONG = 4'hC;
   localparam logic [3:0] OP_GOVLNG = 4'hD;
   localparam logic [3:0] OP_GOSUBL = 4'hE;
   localparam logic [3:0] OP_GOSBVL = 4'hF;
   localparam logic [2:0] JL_REL2   = 3'd1;
   localparam logic [2:0] JL_REL3   = 3'd2;
   localparam logic [2:0] JL_REL4   = 3'd3;
   localparam logic [2:0] JL_ABS5   = 3'd4;
endpackage

// File: rtl/saturn_jump_decoder.sv
// saturn_jump_decoder: decodes GOTO/GOSUB/GOLONG/GOVLNG/GOSUBL/GOSBVL and RTN-family nibble streams.
// Define SATURN_COND_JUMP_EN to add GOC/GONC decoding with a SKIP state for not-taken branches.
module saturn_jump_decoder
   import saturn_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_clk_en,
   input  logic [3:0] i_phases,
   input  logic       i_bus_busy,
   input  logic       i_exec_unit_busy,
   input  logic       i_instr_start,
   input  logic [3:0] i_nibble,
   input  logic       i_carry,
   output logic       o_jump_instr,
   output logic [2:0] o_jump_length,
   output logic       o_push_pc,
   output logic       o_block_0x,
   output logic       o_rtn_instr,
   output logic       o_busy
);
   state_t     state_q;
   logic [2:0] count_q;
   logic       step;
   logic       unused_in;
   assign step   = i_clk_en && !i_bus_busy && !i_exec_unit_busy && i_phases[2];
   assign o_busy = state_q != ST_IDLE;
`ifdef SATURN_COND_JUMP_EN
   logic taken;
   assign taken     = (i_nibble == OP_GOC) == i_carry;
   assign unused_in = i_phases[1];
`else
   assign unused_in = ^{i_phases[1], i_carry};
`endif
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q       <= ST_IDLE;
         count_q       <= '0;
         o_jump_instr  <= 1'b0;
         o_jump_length <= '0;
         o_push_pc     <= 1'b0;
         o_block_0x    <= 1'b0;
         o_rtn_instr   <= 1'b0;
      end else begin
         // the return pulse must span exactly one phase-3 window, even while stalled
         if (i_clk_en && i_phases[0]) o_rtn_instr <= 1'b0;
         if (step) begin
            case (state_q)
               ST_IDLE: if (i_instr_start) begin
                  case (i_nibble)
                     OP_B0: begin
                        state_q    <= ST_B0;
                        o_block_0x <= 1'b1;
                     end
                     OP_GOTO, OP_GOSUB: begin
                        state_q       <= ST_OFFSET;
                        o_jump_instr  <= 1'b1;
                        o_jump_length <= JL_REL3;
                        o_push_pc     <= i_nibble == OP_GOSUB;
                        count_q       <= '0;
                     end
                     OP_8X: state_q <= ST_B8;
`ifdef SATURN_COND_JUMP_EN
                     OP_GOC, OP_GONC: begin
                        state_q       <= taken ? ST_OFFSET : ST_SKIP;
                        o_jump_instr  <= taken;
                        o_jump_length <= JL_REL2;
                        o_push_pc     <= 1'b0;
                        count_q       <= '0;
                     end
`endif
                     default: state_q <= ST_IDLE;
                  endcase
               end
               ST_B0: begin
                  o_block_0x  <= 1'b0;
                  o_rtn_instr <= i_nibble <= 4'h3 || i_nibble == 4'hF;
                  state_q     <= ST_IDLE;
               end
               ST_B8: begin
                  // C..F: bit0 selects 4- vs 5-nibble offset, bit1 selects push
                  state_q       <= i_nibble[3:2] == 2'b11 ? ST_OFFSET : ST_IDLE;
                  o_jump_instr  <= i_nibble[3:2] == 2'b11;
                  o_jump_length <= i_nibble[0] ? JL_ABS5 : JL_REL4;
                  o_push_pc     <= i_nibble[3:2] == 2'b11 && i_nibble[1];
                  count_q       <= '0;
               end
               ST_OFFSET: begin
                  if (count_q == o_jump_length) begin
                     o_jump_instr <= 1'b0;
                     o_push_pc    <= 1'b0;
                     state_q      <= ST_IDLE;
                  end else count_q <= count_q + 3'd1;
               end
`ifdef SATURN_COND_JUMP_EN
               ST_SKIP: begin
                  if (count_q == 3'd1) state_q <= ST_IDLE;
                  else count_q <= count_q + 3'd1;
               end
`endif
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_saturn_jump_decoder.sv
// tb_saturn_jump_decoder: directed nibble sequences with hand-computed expected outputs.
module tb_saturn_jump_decoder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_en = 1'b1;
   logic [3:0] phases = 4'b0001;
   logic       bus_busy = 1'b0, exec_busy = 1'b0, start = 1'b0, carry = 1'b0;
   logic [3:0] nib = 4'h0;
   logic       jump, push, blk, rtn, busy;
   logic [2:0] len;
   int         n_chk = 0, n_pass = 0;

   saturn_jump_decoder dut (
      .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en), .i_phases(phases),
      .i_bus_busy(bus_busy), .i_exec_unit_busy(exec_busy), .i_instr_start(start),
      .i_nibble(nib), .i_carry(carry), .o_jump_instr(jump), .o_jump_length(len),
      .o_push_pc(push), .o_block_0x(blk), .o_rtn_instr(rtn), .o_busy(busy)
   );

   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      #1 phases = {phases[2:0], phases[3]};
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic feed(input logic [3:0] n, input logic s);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!phases[2] && k < 8);
      if (!phases[2]) chk("phase_timeout", 8'd0, 8'd1);
      nib   = n;
      start = s;
      @(posedge clk);
      #2 start = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_jump", {7'd0, jump}, 8'd0);
      chk("rst_len", {5'd0, len}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_rtn", {7'd0, rtn}, 8'd0);
      rst = 1'b0;
      // GOTO rel3; a start strobe mid-offset must be ignored
      feed(4'h6, 1'b1);
      chk("t1_jump", {7'd0, jump}, 8'd1);
      chk("t1_len", {5'd0, len}, 8'd2);
      chk("t1_push", {7'd0, push}, 8'd0);
      feed(4'h3, 1'b0);
      chk("t1_j1", {7'd0, jump}, 8'd1);
      feed(4'h8, 1'b1);
      chk("t1_j2", {7'd0, jump}, 8'd1);
      feed(4'h1, 1'b0);
      chk("t1_end", {7'd0, jump}, 8'd0);
      chk("t1_idle", {7'd0, busy}, 8'd0);
      // GOSBVL abs5
      feed(4'h8, 1'b1);
      chk("t2_8_jump", {7'd0, jump}, 8'd0);
      chk("t2_8_busy", {7'd0, busy}, 8'd1);
      feed(4'hF, 1'b0);
      chk("t2_len", {5'd0, len}, 8'd4);
      chk("t2_push", {7'd0, push}, 8'd1);
      for (int i = 5; i >= 2; i--) begin
         feed(4'(i), 1'b0);
         chk("t2_mid", {7'd0, jump}, 8'd1);
      end
      feed(4'h1, 1'b0);
      chk("t2_end", {7'd0, jump}, 8'd0);
      chk("t2_push_end", {7'd0, push}, 8'd0);
      // RTN pulse
      feed(4'h0, 1'b1);
      chk("t3_blk", {7'd0, blk}, 8'd1);
      feed(4'h1, 1'b0);
      chk("t3_blk_off", {7'd0, blk}, 8'd0);
      chk("t3_rtn_p3", {7'd0, rtn}, 8'd1);
      @(posedge clk);
      #2 chk("t3_rtn_hold", {7'd0, rtn}, 8'd1);
      @(posedge clk);
      #2 chk("t3_rtn_clr", {7'd0, rtn}, 8'd0);
      // non-RTN block-0 and foreign 8A
      feed(4'h0, 1'b1);
      feed(4'h5, 1'b0);
      chk("t4_rtn", {7'd0, rtn}, 8'd0);
      chk("t4_busy", {7'd0, busy}, 8'd0);
      feed(4'h8, 1'b1);
      feed(4'hA, 1'b0);
      chk("t4_8a_busy", {7'd0, busy}, 8'd0);
      chk("t4_8a_jump", {7'd0, jump}, 8'd0);
      // stall mid-offset
      feed(4'h7, 1'b1);
      chk("t5_push", {7'd0, push}, 8'd1);
      feed(4'h1, 1'b0);
      @(negedge clk);
      bus_busy = 1'b1;
      repeat (5) @(posedge clk);
      #2 chk("t5_stall_jump", {7'd0, jump}, 8'd1);
      chk("t5_stall_push", {7'd0, push}, 8'd1);
      bus_busy = 1'b0;
      feed(4'h2, 1'b0);
      chk("t5_j2", {7'd0, jump}, 8'd1);
      feed(4'h3, 1'b0);
      chk("t5_end", {7'd0, jump}, 8'd0);
      // async reset mid-offset
      feed(4'h8, 1'b1);
      feed(4'hD, 1'b0);
      chk("t6_len", {5'd0, len}, 8'd4);
      feed(4'h1, 1'b0);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 chk("t6_rst_jump", {7'd0, jump}, 8'd0);
      chk("t6_rst_len", {5'd0, len}, 8'd0);
      chk("t6_rst_busy", {7'd0, busy}, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      feed(4'h6, 1'b1);
      chk("t6_re_len", {5'd0, len}, 8'd2);
      for (int i = 0; i < 2; i++) feed(4'h9, 1'b0);
      chk("t6_re_mid", {7'd0, jump}, 8'd1);
      feed(4'h9, 1'b0);
      chk("t6_re_end", {7'd0, jump}, 8'd0);
`ifdef SATURN_COND_JUMP_EN
      carry = 1'b1;
      feed(4'h4, 1'b1);
      chk("c_taken_jump", {7'd0, jump}, 8'd1);
      chk("c_taken_len", {5'd0, len}, 8'd1);
      feed(4'h2, 1'b0);
      chk("c_taken_mid", {7'd0, jump}, 8'd1);
      feed(4'h1, 1'b0);
      chk("c_taken_end", {7'd0, jump}, 8'd0);
      carry = 1'b0;
      feed(4'h4, 1'b1);
      chk("c_skip_jump", {7'd0, jump}, 8'd0);
      chk("c_skip_busy", {7'd0, busy}, 8'd1);
      feed(4'h2, 1'b0);
      chk("c_skip_mid", {7'd0, busy}, 8'd1);
      feed(4'h1, 1'b0);
      chk("c_skip_end", {7'd0, busy}, 8'd0);
`else
      feed(4'h4, 1'b1);
      chk("c_off_busy", {7'd0, busy}, 8'd0);
      chk("c_off_jump", {7'd0, jump}, 8'd0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
